// File: rtl/jpeg_seq_pkg.sv
// Shared constants for the JPEG block sequencer: state codes, row count,
// default stage latencies and counter widths.
package jpeg_seq_pkg;
  localparam int ROWS          = 8;
  localparam int DEF_DCT_LAT   = 8;
  localparam int DEF_QUANT_LAT = 1;
  localparam int COMP_W        = 2;
  localparam int CNT_W         = 16;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_DCT       = 3'd2;
  localparam logic [2:0] ST_CAPT      = 3'd3;
  localparam logic [2:0] ST_QUANT     = 3'd4;
  localparam logic [2:0] ST_ZIGZAG    = 3'd5;
  localparam logic [2:0] ST_HSTART    = 3'd6;
  localparam logic [2:0] ST_WAIT_HUFF = 3'd7;
endpackage

// File: rtl/jpeg_seq_counter.sv
// Loadable down-counter with zero flag; holds at zero, clr has priority over load.
module jpeg_seq_counter
  import jpeg_seq_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                         cnt_d = '0;
    else if (load)                   cnt_d = load_val;
    else if (dec && (cnt_q != '0))   cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);
endmodule

// File: rtl/jpeg_block_sequencer.sv
// Block-level control sequencer for the JPEG encoder datapath: one valid/ready
// handshake per 8x8 block drives every stage enable, component rotation and restart.
module jpeg_block_sequencer
  import jpeg_seq_pkg::*;
#(
  parameter int         DCT_LAT      = DEF_DCT_LAT,
  parameter int         QUANT_LAT    = DEF_QUANT_LAT,
  parameter int         NUM_COMP     = 3,
  parameter logic [3:0] LUMA_MASK    = 4'b0001,
  parameter int         HUFF_TIMEOUT = 1024,
  parameter int         RESTART_MCUS = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       abort,
  input  logic       blk_valid,
  output logic       blk_ready,
  input  logic       huff_done,
  output logic       input_enable,
  output logic       dct_enable,
  output logic       dct_end_enable,
  output logic [7:0] matrix_row,
  output logic       zigzag_input_enable,
  output logic       zigag_enable,
  output logic       Huffman_start,
  output logic       is_luminance,
  output logic [1:0] comp_idx,
  output logic       mcu_done,
  output logic       dc_pred_reset,
  output logic       huff_timeout,
  output logic       busy
);
  localparam logic [CNT_W-1:0]  DCT_LD    = CNT_W'(DCT_LAT - 1);
  localparam logic [CNT_W-1:0]  QUANT_LD  = CNT_W'(QUANT_LAT);
  localparam logic [CNT_W-1:0]  WD_LD     = CNT_W'(HUFF_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  RST_LD    = CNT_W'(RESTART_MCUS - 1);
  localparam logic [COMP_W-1:0] LAST_COMP = COMP_W'(NUM_COMP - 1);
  localparam logic [2:0]        LAST_ROW  = 3'(ROWS - 1);

  state_t             state_q, state_d;
  logic [COMP_W-1:0]  comp_q, comp_d;
  logic [2:0]         row_q, row_d;

  logic               hold_ld, hold_dec, hold_zero;
  logic [CNT_W-1:0]   hold_val, hold_cnt;
  logic               mcu_clr, mcu_ld, mcu_dec, mcu_zero;
  logic [CNT_W-1:0]   mcu_cnt;

  logic               zin_d, mcu_done_d, dcr_d, hto_d;
  logic               blk_ready_q, blk_ready_d, input_enable_q, input_enable_d;
  logic               dct_enable_q, dct_enable_d, dct_end_q, dct_end_d;
  logic [7:0]         matrix_row_q, matrix_row_d;
  logic               zin_q, zen_q, zen_d, hstart_q, hstart_d, lum_q, lum_d;
  logic               mcu_done_q, dcr_q, hto_q, busy_q, busy_d;

  // One counter times the DCT hold, each row hold and the Huffman watchdog.
  jpeg_seq_counter #(.W(CNT_W)) u_hold (
    .clock(clock), .reset_n(reset_n), .clr(abort), .load(hold_ld),
    .load_val(hold_val), .dec(hold_dec), .count(hold_cnt), .zero(hold_zero)
  );

  jpeg_seq_counter #(.W(CNT_W)) u_mcu (
    .clock(clock), .reset_n(reset_n), .clr(mcu_clr), .load(mcu_ld),
    .load_val(RST_LD), .dec(mcu_dec), .count(mcu_cnt), .zero(mcu_zero)
  );

  always_comb begin
    state_d    = state_q;
    comp_d     = comp_q;
    row_d      = row_q;
    hold_ld    = 1'b0;
    hold_val   = '0;
    hold_dec   = 1'b0;
    mcu_clr    = 1'b0;
    mcu_ld     = 1'b0;
    mcu_dec    = 1'b0;
    zin_d      = 1'b0;
    mcu_done_d = 1'b0;
    dcr_d      = 1'b0;
    hto_d      = 1'b0;
    case (state_q)
      ST_IDLE: if (blk_valid) begin
        state_d  = ST_LOAD;
        hold_ld  = 1'b1;
        hold_val = DCT_LD;
      end
      ST_LOAD: state_d = ST_DCT;
      ST_DCT: begin
        if (hold_zero) state_d = ST_CAPT;
        else           hold_dec = 1'b1;
      end
      ST_CAPT: begin
        state_d  = ST_QUANT;
        row_d    = '0;
        hold_ld  = 1'b1;
        hold_val = QUANT_LD;
        zin_d    = (QUANT_LAT == 0);
      end
      ST_QUANT: begin
        // zigzag capture lands on the final held cycle of each row
        if (!hold_zero) begin
          hold_dec = 1'b1;
          zin_d    = (hold_cnt == CNT_W'(1));
        end else if (row_q == LAST_ROW) begin
          state_d = ST_ZIGZAG;
        end else begin
          row_d    = row_q + 3'd1;
          hold_ld  = 1'b1;
          hold_val = QUANT_LD;
          zin_d    = (QUANT_LAT == 0);
        end
      end
      ST_ZIGZAG: state_d = ST_HSTART;
      ST_HSTART: begin
        state_d  = ST_WAIT_HUFF;
        hold_ld  = 1'b1;
        hold_val = WD_LD;
      end
      ST_WAIT_HUFF: begin
        if (huff_done) begin
          state_d = ST_IDLE;
          if (comp_q == LAST_COMP) begin
            comp_d     = '0;
            mcu_done_d = 1'b1;
            if (RESTART_MCUS != 0) begin
              if ((RESTART_MCUS == 1) || (mcu_cnt == CNT_W'(1))) begin
                dcr_d   = 1'b1;
                mcu_clr = 1'b1;
              end else if (mcu_zero) begin
                mcu_ld = 1'b1;
              end else begin
                mcu_dec = 1'b1;
              end
            end
          end else begin
            comp_d = comp_q + COMP_W'(1);
          end
        end else if (hold_zero) begin
          state_d = ST_IDLE;
          hto_d   = 1'b1;
        end else begin
          hold_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d    = ST_IDLE;
      comp_d     = '0;
      row_d      = '0;
      hold_ld    = 1'b0;
      hold_dec   = 1'b0;
      mcu_ld     = 1'b0;
      mcu_dec    = 1'b0;
      mcu_clr    = 1'b1;
      zin_d      = 1'b0;
      mcu_done_d = 1'b0;
      dcr_d      = 1'b0;
      hto_d      = 1'b0;
    end
  end

  // Outputs are decoded from the next state so that every pin is a flop.
  always_comb begin
    blk_ready_d    = (state_d == ST_IDLE);
    busy_d         = (state_d != ST_IDLE);
    input_enable_d = (state_d == ST_LOAD);
    dct_enable_d   = (state_d == ST_DCT);
    dct_end_d      = (state_d == ST_CAPT);
    matrix_row_d   = (state_d == ST_QUANT) ? {5'd0, row_d} : 8'd0;
    zen_d          = (state_d == ST_ZIGZAG);
    hstart_d       = (state_d == ST_HSTART);
    lum_d          = LUMA_MASK[comp_d];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      comp_q         <= '0;
      row_q          <= '0;
      blk_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
      input_enable_q <= 1'b0;
      dct_enable_q   <= 1'b0;
      dct_end_q      <= 1'b0;
      matrix_row_q   <= '0;
      zin_q          <= 1'b0;
      zen_q          <= 1'b0;
      hstart_q       <= 1'b0;
      lum_q          <= LUMA_MASK[0];
      mcu_done_q     <= 1'b0;
      dcr_q          <= 1'b0;
      hto_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      comp_q         <= comp_d;
      row_q          <= row_d;
      blk_ready_q    <= blk_ready_d;
      busy_q         <= busy_d;
      input_enable_q <= input_enable_d;
      dct_enable_q   <= dct_enable_d;
      dct_end_q      <= dct_end_d;
      matrix_row_q   <= matrix_row_d;
      zin_q          <= zin_d;
      zen_q          <= zen_d;
      hstart_q       <= hstart_d;
      lum_q          <= lum_d;
      mcu_done_q     <= mcu_done_d;
      dcr_q          <= dcr_d;
      hto_q          <= hto_d;
    end
  end

  assign blk_ready           = blk_ready_q;
  assign busy                = busy_q;
  assign input_enable        = input_enable_q;
  assign dct_enable          = dct_enable_q;
  assign dct_end_enable      = dct_end_q;
  assign matrix_row          = matrix_row_q;
  assign zigzag_input_enable = zin_q;
  assign zigag_enable        = zen_q;
  assign Huffman_start       = hstart_q;
  assign is_luminance        = lum_q;
  assign comp_idx            = comp_q;
  assign mcu_done            = mcu_done_q;
  assign dc_pred_reset       = dcr_q;
  assign huff_timeout        = hto_q;
endmodule

// File: tb/tb_jpeg_block_sequencer.sv
// Bench for jpeg_block_sequencer: DUT A uses default latencies with a 2-MCU
// restart interval, DUT B uses short latencies and a 4-cycle Huffman watchdog.
module tb_jpeg_block_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_a, abort_a, blk_valid_a, huff_done_a;
  logic       blk_ready_a, input_enable_a, dct_enable_a, dct_end_a;
  logic [7:0] matrix_row_a;
  logic       zig_in_a, zig_en_a, hstart_a, is_lum_a, mcu_done_a, dcr_a, hto_a, busy_a;
  logic [1:0] comp_a;

  logic       rst_n_b, abort_b, blk_valid_b, huff_done_b;
  logic       blk_ready_b, input_enable_b, dct_enable_b, dct_end_b;
  logic [7:0] matrix_row_b;
  logic       zig_in_b, zig_en_b, hstart_b, is_lum_b, mcu_done_b, dcr_b, hto_b, busy_b;
  logic [1:0] comp_b;

  jpeg_block_sequencer #(
    .DCT_LAT(8), .QUANT_LAT(1), .NUM_COMP(3), .LUMA_MASK(4'b0001),
    .HUFF_TIMEOUT(1024), .RESTART_MCUS(2)
  ) dut_a (
    .clock(clk), .reset_n(rst_n_a), .abort(abort_a), .blk_valid(blk_valid_a),
    .blk_ready(blk_ready_a), .huff_done(huff_done_a), .input_enable(input_enable_a),
    .dct_enable(dct_enable_a), .dct_end_enable(dct_end_a), .matrix_row(matrix_row_a),
    .zigzag_input_enable(zig_in_a), .zigag_enable(zig_en_a), .Huffman_start(hstart_a),
    .is_luminance(is_lum_a), .comp_idx(comp_a), .mcu_done(mcu_done_a),
    .dc_pred_reset(dcr_a), .huff_timeout(hto_a), .busy(busy_a)
  );

  jpeg_block_sequencer #(
    .DCT_LAT(1), .QUANT_LAT(0), .NUM_COMP(3), .LUMA_MASK(4'b0001),
    .HUFF_TIMEOUT(4), .RESTART_MCUS(0)
  ) dut_b (
    .clock(clk), .reset_n(rst_n_b), .abort(abort_b), .blk_valid(blk_valid_b),
    .blk_ready(blk_ready_b), .huff_done(huff_done_b), .input_enable(input_enable_b),
    .dct_enable(dct_enable_b), .dct_end_enable(dct_end_b), .matrix_row(matrix_row_b),
    .zigzag_input_enable(zig_in_b), .zigag_enable(zig_en_b), .Huffman_start(hstart_b),
    .is_luminance(is_lum_b), .comp_idx(comp_b), .mcu_done(mcu_done_b),
    .dc_pred_reset(dcr_b), .huff_timeout(hto_b), .busy(busy_b)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0] comp;
    logic       mcu;
    logic       dcr;
  } blk_exp_t;

  logic [16:0] exp_q[$];
  blk_exp_t    blk_q[$];

  // {ie, dct_en, dct_end, zig_in, zig_en, hstart, timeout, blk_ready, busy, row[7:0]}
  localparam logic [16:0] RST_VEC  = 17'h00200;
  // {comp_idx, is_luminance, mcu_done, dc_pred_reset}
  localparam logic [4:0]  RST_SIDE = 5'b00100;

  function automatic logic [16:0] vec(input bit sel);
    if (sel)
      return {input_enable_b, dct_enable_b, dct_end_b, zig_in_b, zig_en_b, hstart_b,
              hto_b, blk_ready_b, busy_b, matrix_row_b};
    return {input_enable_a, dct_enable_a, dct_end_a, zig_in_a, zig_en_a, hstart_a,
            hto_a, blk_ready_a, busy_a, matrix_row_a};
  endfunction

  function automatic logic [4:0] side(input bit sel);
    if (sel) return {comp_b, is_lum_b, mcu_done_b, dcr_b};
    return {comp_a, is_lum_a, mcu_done_a, dcr_a};
  endfunction

  // Expected output vector k cycles after the handshake cycle.
  function automatic logic [16:0] model(input int dl, input int q, input int to,
                                        input int done_k, input int k);
    int hs, qs, ws, endk;
    logic [7:0] row;
    logic zi;
    hs   = 4 + dl + 8 * (q + 1);
    qs   = 3 + dl;
    ws   = hs + 1;
    endk = (done_k != 0) ? done_k + 1 : ws + to;
    row  = 8'd0;
    zi   = 1'b0;
    if (k >= qs && k < qs + 8 * (q + 1)) begin
      row = 8'((k - qs) / (q + 1));
      zi  = (((k - qs) % (q + 1)) == q);
    end
    return {k == 1, (k >= 2 && k <= 1 + dl), k == 2 + dl, zi, k == hs - 1, k == hs,
            (done_k == 0 && k == endk), k >= endk, k < endk, row};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_valid(input bit sel, input logic v);
    if (sel) blk_valid_b = v; else blk_valid_a = v;
  endtask

  task automatic set_done(input bit sel, input logic v);
    if (sel) huff_done_b = v; else huff_done_a = v;
  endtask

  task automatic run_block(input bit sel, input int dl, input int q, input int to,
                           input int done_k, input int n, input string name);
    logic [16:0] got, e;
    got = vec(sel);
    checks++;
    if (got[9] !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_at_start got=%b exp=1", name, got[9]);
    end
    for (int k = 1; k <= n; k++) exp_q.push_back(model(dl, q, to, done_k, k));
    set_valid(sel, 1'b1);
    for (int k = 1; k <= n; k++) begin
      tick();
      if (k == 1) set_valid(sel, 1'b0);
      set_done(sel, k == done_k);
      got = vec(sel);
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL %s k=%0d got=%h exp=%h", name, k, got, e);
      end
    end
    set_done(sel, 1'b0);
  endtask

  task automatic test_reset();
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (vec(s[0]) !== RST_VEC) begin
        failures++;
        $display("FAIL reset_vec dut=%0d got=%h exp=%h", s, vec(s[0]), RST_VEC);
      end
      checks++;
      if (side(s[0]) !== RST_SIDE) begin
        failures++;
        $display("FAIL reset_side dut=%0d got=%b exp=%b", s, side(s[0]), RST_SIDE);
      end
    end
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    tick();
  endtask

  task automatic test_default_block();
    run_block(1'b0, 8, 1, 1024, 35, 36, "default");
    checks++;
    if (side(1'b0) !== 5'b01000) begin
      failures++;
      $display("FAIL default_side got=%b exp=%b", side(1'b0), 5'b01000);
    end
  endtask

  task automatic test_sync_reset();
    set_valid(1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) set_valid(1'b0, 1'b0);
    end
    checks++;
    if (dct_enable_a !== 1'b1) begin
      failures++;
      $display("FAIL mid_dct got=%b exp=1", dct_enable_a);
    end
    rst_n_a = 1'b0;
    #3;
    checks++;
    if ({dct_enable_a, busy_a} !== 2'b11) begin
      failures++;
      $display("FAIL reset_no_edge got=%b exp=11", {dct_enable_a, busy_a});
    end
    @(posedge clk);
    #1;
    rst_n_a = 1'b1;
    checks++;
    if (vec(1'b0) !== RST_VEC) begin
      failures++;
      $display("FAIL sync_reset_vec got=%h exp=%h", vec(1'b0), RST_VEC);
    end
    checks++;
    if (side(1'b0) !== RST_SIDE) begin
      failures++;
      $display("FAIL sync_reset_side got=%b exp=%b", side(1'b0), RST_SIDE);
    end
    tick();
    tick();
    checks++;
    if (vec(1'b0) !== RST_VEC) begin
      failures++;
      $display("FAIL after_reset_idle got=%h exp=%h", vec(1'b0), RST_VEC);
    end
  endtask

  task automatic test_abort();
    run_block(1'b0, 8, 1, 1024, 35, 36, "pre_abort");
    set_valid(1'b0, 1'b1);
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 1) set_valid(1'b0, 1'b0);
    end
    checks++;
    if ({matrix_row_a, comp_a} !== {8'd3, 2'd1}) begin
      failures++;
      $display("FAIL abort_row3 got=%h exp=%h", {matrix_row_a, comp_a}, {8'd3, 2'd1});
    end
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    checks++;
    if (vec(1'b0) !== RST_VEC) begin
      failures++;
      $display("FAIL abort_vec got=%h exp=%h", vec(1'b0), RST_VEC);
    end
    checks++;
    if (side(1'b0) !== RST_SIDE) begin
      failures++;
      $display("FAIL abort_side got=%b exp=%b", side(1'b0), RST_SIDE);
    end
  endtask

  task automatic test_back_to_back_restart();
    int nblk, ndone, mcu_cnt, dcr_cnt;
    logic prev_busy;
    blk_exp_t e, got;
    nblk = 0; ndone = 0; mcu_cnt = 0; dcr_cnt = 0; prev_busy = 1'b0;
    blk_valid_a = 1'b1;
    huff_done_a = 1'b1;
    for (int c = 0; c < 400 && ndone < 6; c++) begin
      tick();
      if (input_enable_a) begin
        checks++;
        if (comp_a !== 2'(nblk % 3)) begin
          failures++;
          $display("FAIL b2b_comp blk=%0d got=%0d exp=%0d", nblk, comp_a, nblk % 3);
        end
        e.comp = 2'((nblk + 1) % 3);
        e.mcu  = (nblk % 3 == 2);
        e.dcr  = (nblk == 5);
        blk_q.push_back(e);
        nblk++;
      end
      if (mcu_done_a) mcu_cnt++;
      if (dcr_a) dcr_cnt++;
      if (prev_busy && !busy_a) begin
        got = {comp_a, mcu_done_a, dcr_a};
        checks++;
        if (blk_q.size() == 0) begin
          failures++;
          $display("FAIL b2b_unexpected_done got=%b", got);
        end else begin
          e = blk_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL b2b_done blk=%0d got=%b exp=%b", ndone, got, e);
          end
        end
        ndone++;
        if (ndone == 6) begin
          blk_valid_a = 1'b0;
          huff_done_a = 1'b0;
        end
      end
      prev_busy = busy_a;
    end
    blk_valid_a = 1'b0;
    huff_done_a = 1'b0;
    checks++;
    if (ndone != 6) begin
      failures++;
      $display("FAIL b2b_timeout got=%0d blocks exp=6", ndone);
    end
    checks++;
    if ({mcu_cnt, dcr_cnt} !== {32'd2, 32'd1}) begin
      failures++;
      $display("FAIL b2b_pulses got mcu=%0d dcr=%0d exp mcu=2 dcr=1", mcu_cnt, dcr_cnt);
    end
    tick();
    checks++;
    if (vec(1'b0) !== RST_VEC) begin
      failures++;
      $display("FAIL b2b_idle got=%h exp=%h", vec(1'b0), RST_VEC);
    end
  endtask

  task automatic test_fast_timeout();
    run_block(1'b1, 1, 0, 4, 0, 20, "timeout");
    checks++;
    if (side(1'b1) !== 5'b00100) begin
      failures++;
      $display("FAIL timeout_side got=%b exp=%b", side(1'b1), 5'b00100);
    end
  endtask

  task automatic test_retry();
    run_block(1'b1, 1, 0, 4, 15, 17, "retry");
    checks++;
    if (side(1'b1) !== 5'b01000) begin
      failures++;
      $display("FAIL retry_side got=%b exp=%b", side(1'b1), 5'b01000);
    end
  endtask

  task automatic test_done_at_timeout();
    run_block(1'b1, 1, 0, 4, 17, 19, "done_vs_timeout");
    checks++;
    if (side(1'b1) !== 5'b10000) begin
      failures++;
      $display("FAIL done_vs_timeout_side got=%b exp=%b", side(1'b1), 5'b10000);
    end
  endtask

  initial begin
    rst_n_a = 1'b0; abort_a = 1'b0; blk_valid_a = 1'b0; huff_done_a = 1'b0;
    rst_n_b = 1'b0; abort_b = 1'b0; blk_valid_b = 1'b0; huff_done_b = 1'b0;
    test_reset();
    test_default_block();
    test_sync_reset();
    test_abort();
    test_back_to_back_restart();
    test_fast_timeout();
    test_retry();
    test_done_at_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jpeg_block_sequencer.md
# jpeg_block_sequencer

Parametrised control sequencer for the JPEG encoder datapath (input buffer → DCT_2D → DCT buffer → Quantize → zigzag buffer → Huffman_enc_controller). It replaces the hand-driven enable pins of the encoder top with a single valid/ready block handshake. It generates every stage enable with configurable stage latencies. It also cycles the component index across an interleaved MCU of up to 4 components, watchdogs the Huffman stage, and signals restart intervals.

## Interface
- DCT_LAT, 8, cycles `dct_enable` is held (DCT_2D compute latency), 1..255
- QUANT_LAT, 1, Quantize pipeline depth; each row is held QUANT_LAT+1 cycles, 0..15
- NUM_COMP, 3, blocks per MCU (components), 1..4
- LUMA_MASK, 4'b0001, bit c=1 → component c uses the luminance tables
- HUFF_TIMEOUT, 1024, max cycles in WAIT_HUFF before error, ≥2
- RESTART_MCUS, 0, MCUs per restart interval; 0 disables restart
- clock  in  1  system clock
- reset_n  in  1  reset, synchronous, active-low
- abort  in  1  soft clear, priority over all other inputs
- blk_valid  in  1  upstream has a 64-pixel block on the buffer input bus
- blk_ready  out  1  sequencer accepts a block (IDLE only)
- huff_done  in  1  Huffman controller finished current block
- input_enable  out  1  one-cycle load strobe to the input buffer
- dct_enable  out  1  DCT_2D run
- dct_end_enable  out  1  one-cycle capture strobe to the DCT buffer
- matrix_row  out  8  row index to Quantize/zigzag, 0..7
- zigzag_input_enable  out  1  zigzag row capture strobe
- zigag_enable  out  1  one-cycle zigzag reorder strobe
- Huffman_start  out  1  one-cycle Huffman kick
- is_luminance  out  1  LUMA_MASK[comp_idx]
- comp_idx  out  2  current component
- mcu_done  out  1  one-cycle pulse, last component of MCU finished
- dc_pred_reset  out  1  one-cycle pulse at restart-interval boundary
- huff_timeout  out  1  one-cycle error pulse
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, LOAD, DCT, CAPT, QUANT, ZIGZAG, HSTART, WAIT_HUFF.
- IDLE: `blk_ready`=1; `blk_valid`&`blk_ready` → LOAD.
- LOAD (1 cycle): `input_enable`=1 → DCT.
- DCT (DCT_LAT cycles): `dct_enable`=1 → CAPT.
- CAPT (1 cycle): `dct_end_enable`=1 → QUANT, row=0.
- QUANT: `matrix_row`=r held QUANT_LAT+1 cycles; `zigzag_input_enable`=1 on the last of them; after r=7 → ZIGZAG.
- ZIGZAG (1 cycle): `zigag_enable`=1 → HSTART.
- HSTART (1 cycle): `Huffman_start`=1 → WAIT_HUFF, watchdog cleared.
- WAIT_HUFF: on `huff_done` → IDLE; comp_idx advances, wrapping NUM_COMP-1→0.
  - On wrap: `mcu_done` pulses and the MCU counter increments.
  - When the MCU counter reaches RESTART_MCUS (≠0): `dc_pred_reset` pulses and the counter returns to 0.
- Watchdog: HUFF_TIMEOUT cycles in WAIT_HUFF without `huff_done` → `huff_timeout` pulse → IDLE; comp_idx and MCU counter unchanged (block is retried).
- `huff_done` outside WAIT_HUFF is ignored.
- `huff_done` in the same cycle as the timeout: done wins, no error.
- `abort` or reset: next edge → IDLE; all strobes 0, comp_idx 0, MCU counter 0, watchdog 0. No `mcu_done` or `dc_pred_reset` is generated.
- Reset values: every output 0, except `blk_ready`=1 (IDLE), `is_luminance`=LUMA_MASK[0].
- All outputs are registered. `is_luminance` updates in the same cycle as `comp_idx`.

## Timing
- Defaults, handshake at cycle T:
  - `input_enable` at T+1
  - `dct_enable` T+2..T+9
  - `dct_end_enable` T+10
  - row r on `matrix_row` T+11+2r..T+12+2r; `zigzag_input_enable` at T+12+2r
  - `zigag_enable` T+27
  - `Huffman_start` T+28
  - WAIT_HUFF from T+29
- General: `Huffman_start` at T+3+DCT_LAT+8·(QUANT_LAT+1)+1.
- `huff_done` at D → `blk_ready`=1, new `comp_idx`, and `mcu_done`/`dc_pred_reset` all at D+1. Earliest next handshake is D+1.
- `blk_valid` may be held across busy cycles; it is not consumed until IDLE.

## Structure
- Package `jpeg_seq_pkg`: state enum, row count constant (8), default latency constants, component-index width.
- One sub-module, `jpeg_seq_counter`: loadable down-counter with zero flag. Instance 1 handles DCT hold, row hold and watchdog; instance 2 is the MCU counter.

## Test plan
- Defaults, one block, `huff_done` at T+35:
  - strobes at exactly T+1/T+2–9/T+10/T+12,14…26/T+27/T+28
  - `blk_ready` back at T+36
  - `comp_idx`=1, `is_luminance`=0
- NUM_COMP=3, RESTART_MCUS=2, 6 blocks with `blk_valid` held high and immediate `huff_done`:
  - `comp_idx` sequence 0,1,2,0,1,2
  - `mcu_done` after blocks 3 and 6
  - single `dc_pred_reset` after block 6
- HUFF_TIMEOUT=4, no `huff_done`:
  - `huff_timeout` pulse 4 cycles after entering WAIT_HUFF
  - IDLE, `comp_idx` unchanged
  - retry completes normally
- `huff_done` in the timeout cycle → no `huff_timeout`, `comp_idx` advances.
- `abort` in the QUANT state, row 3 → next cycle all strobes 0, `matrix_row`=0, `comp_idx`=0, `blk_ready`=1.
- `reset_n` low mid-DCT for 1 cycle → all outputs at reset values on the next edge. `reset_n` low without a clock edge → no change (synchronous reset).
- DCT_LAT=1, QUANT_LAT=0 → `Huffman_start` at T+13.
